// File: rtl/mux_arb_n.sv
// ---------------------------------------------------------------------------
// mux_arb_n : NCH-way arbitrated multiplexer with a registered output stage.
//
// Each cycle, one requesting input channel is picked. The pick is either
// round-robin (MODE 0) or fixed priority with the lowest index winning
// (MODE 1). The winner's word is captured into a single output register
// whenever that register is empty or is being drained in the same cycle.
//
// Ports
//   CLK        : clock, rising edge
//   RST_n      : asynchronous active-low reset
//   In_valid   : [NCH]        per-channel request
//   In_data    : [NCH*WIDTH]  channel i at [i*WIDTH +: WIDTH]
//   In_ready   : [NCH]        per-channel accept, at most one bit set
//   Out_valid  : output register holds a word
//   Out_ready  : downstream accepts the held word
//   Out_data   : [WIDTH]      registered word
//   Out_ch     : [CW]         channel that supplied Out_data
// ---------------------------------------------------------------------------
module mux_arb_n #(
    parameter  int WIDTH = 32,
    parameter  int NCH   = 4,
    parameter  int MODE  = 0,
    localparam int CW    = $clog2(NCH)
) (
    input  logic                 CLK,
    input  logic                 RST_n,
    input  logic [NCH-1:0]       In_valid,
    input  logic [NCH*WIDTH-1:0] In_data,
    output logic [NCH-1:0]       In_ready,
    output logic                 Out_valid,
    input  logic                 Out_ready,
    output logic [WIDTH-1:0]     Out_data,
    output logic [CW-1:0]        Out_ch
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic [CW-1:0]    r_ch;
    logic [CW-1:0]    r_ptr;

    logic             w_load;
    logic             w_any;
    logic [NCH-1:0]   w_grant;
    logic [CW-1:0]    w_gidx;
    logic [WIDTH-1:0] w_sel_data;

    // The output register can take a new word when empty or draining now.
    assign w_load = !r_valid || Out_ready;

    // Grant search. Both loops walk from the least to the most preferred
    // candidate so that the last hit (the most preferred) wins.
    always_comb begin
        int j;
        j       = 0;
        w_grant = '0;
        w_gidx  = '0;
        w_any   = 1'b0;
        if (MODE == 1) begin
            for (int i = NCH - 1; i >= 0; i--) begin
                if (In_valid[CW'(i)]) begin
                    w_grant           = '0;
                    w_grant[CW'(i)]   = 1'b1;
                    w_gidx            = CW'(i);
                    w_any             = 1'b1;
                end
            end
        end else begin
            // Offset k = 1 is the channel right after the last winner.
            for (int k = NCH; k >= 1; k--) begin
                j = int'(r_ptr) + k;
                if (j >= NCH) j = j - NCH;
                if (In_valid[CW'(j)]) begin
                    w_grant           = '0;
                    w_grant[CW'(j)]   = 1'b1;
                    w_gidx            = CW'(j);
                    w_any             = 1'b1;
                end
            end
        end
    end

    // One-hot select of the granted channel's word.
    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < NCH; i++) begin
            if (w_grant[CW'(i)]) w_sel_data = In_data[i*WIDTH +: WIDTH];
        end
    end

    // RST_n gating keeps every accept low while the block is held in reset.
    assign In_ready = (RST_n && w_load) ? w_grant : '0;

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_ch    <= '0;
            r_ptr   <= CW'(NCH - 1);   // search starts at channel 0
        end else if (w_load) begin
            if (w_any) begin
                r_valid <= 1'b1;
                r_data  <= w_sel_data;
                r_ch    <= w_gidx;
                r_ptr   <= w_gidx;
            end else begin
                // Word and channel are kept visible after the drain.
                r_valid <= 1'b0;
            end
        end
    end

    assign Out_valid = r_valid;
    assign Out_data  = r_data;
    assign Out_ch    = r_ch;

endmodule

// File: tb/tb_mux_arb_n.sv
// ---------------------------------------------------------------------------
// tb_mux_arb_n : self-checking bench for mux_arb_n.
// Four instances run in lockstep: (32,4,RR), (32,4,FP), (8,2,RR), (64,5,RR).
// A behavioural model (arbitration by minimum circular distance) predicts
// In_ready and the registered outputs of every instance each cycle; table
// vectors and directed sequences add fixed expected values on top.
// ---------------------------------------------------------------------------
module tb_mux_arb_n;

    localparam int NI = 4;

    logic CLK = 1'b0;
    logic RST_n;
    always #5 CLK = ~CLK;

    // Per-instance stimulus
    logic [15:0] t_iv [NI];
    logic        t_or [NI];
    logic [63:0] t_d  [NI][16];

    // Instance parameters as seen by the model
    int m_nch  [NI] = '{4, 4, 2, 5};
    int m_mode [NI] = '{0, 1, 0, 0};
    int m_w    [NI] = '{32, 32, 8, 64};

    // Model state
    logic        m_ov   [NI];
    logic [63:0] m_od   [NI];
    int          m_oc   [NI];
    int          m_last [NI];
    int          m_g    [NI];

    // DUT signals
    logic [3:0]   rr_iv, rr_ir, fp_iv, fp_ir;
    logic [127:0] rr_id, fp_id;
    logic         rr_ov, rr_or, fp_ov, fp_or;
    logic [31:0]  rr_od, fp_od;
    logic [1:0]   rr_oc, fp_oc;
    logic [1:0]   s2_iv, s2_ir;
    logic [15:0]  s2_id;
    logic         s2_ov, s2_or;
    logic [7:0]   s2_od;
    logic [0:0]   s2_oc;
    logic [4:0]   s5_iv, s5_ir;
    logic [319:0] s5_id;
    logic         s5_ov, s5_or;
    logic [63:0]  s5_od;
    logic [2:0]   s5_oc;

    logic [15:0] a_ir [NI];
    logic        a_ov [NI];
    logic [63:0] a_od [NI];
    logic [7:0]  a_oc [NI];

    int n_cmp  = 0;
    int n_fail = 0;

    mux_arb_n #(.WIDTH(32), .NCH(4), .MODE(0)) u_rr (
        .CLK(CLK), .RST_n(RST_n), .In_valid(rr_iv), .In_data(rr_id), .In_ready(rr_ir),
        .Out_valid(rr_ov), .Out_ready(rr_or), .Out_data(rr_od), .Out_ch(rr_oc));
    mux_arb_n #(.WIDTH(32), .NCH(4), .MODE(1)) u_fp (
        .CLK(CLK), .RST_n(RST_n), .In_valid(fp_iv), .In_data(fp_id), .In_ready(fp_ir),
        .Out_valid(fp_ov), .Out_ready(fp_or), .Out_data(fp_od), .Out_ch(fp_oc));
    mux_arb_n #(.WIDTH(8), .NCH(2), .MODE(0)) u_s2 (
        .CLK(CLK), .RST_n(RST_n), .In_valid(s2_iv), .In_data(s2_id), .In_ready(s2_ir),
        .Out_valid(s2_ov), .Out_ready(s2_or), .Out_data(s2_od), .Out_ch(s2_oc));
    mux_arb_n #(.WIDTH(64), .NCH(5), .MODE(0)) u_s5 (
        .CLK(CLK), .RST_n(RST_n), .In_valid(s5_iv), .In_data(s5_id), .In_ready(s5_ir),
        .Out_valid(s5_ov), .Out_ready(s5_or), .Out_data(s5_od), .Out_ch(s5_oc));

    always_comb begin
        rr_iv = t_iv[0][3:0]; rr_or = t_or[0];
        fp_iv = t_iv[1][3:0]; fp_or = t_or[1];
        s2_iv = t_iv[2][1:0]; s2_or = t_or[2];
        s5_iv = t_iv[3][4:0]; s5_or = t_or[3];
        rr_id = '0; fp_id = '0; s2_id = '0; s5_id = '0;
        for (int c = 0; c < 4; c++) begin
            rr_id[c*32 +: 32] = t_d[0][c][31:0];
            fp_id[c*32 +: 32] = t_d[1][c][31:0];
        end
        for (int c = 0; c < 2; c++) s2_id[c*8 +: 8]   = t_d[2][c][7:0];
        for (int c = 0; c < 5; c++) s5_id[c*64 +: 64] = t_d[3][c];
    end

    always_comb begin
        a_ir[0] = 16'(rr_ir); a_ov[0] = rr_ov; a_od[0] = 64'(rr_od); a_oc[0] = 8'(rr_oc);
        a_ir[1] = 16'(fp_ir); a_ov[1] = fp_ov; a_od[1] = 64'(fp_od); a_oc[1] = 8'(fp_oc);
        a_ir[2] = 16'(s2_ir); a_ov[2] = s2_ov; a_od[2] = 64'(s2_od); a_oc[2] = 8'(s2_oc);
        a_ir[3] = 16'(s5_ir); a_ov[3] = s5_ov; a_od[3] = 64'(s5_od); a_oc[3] = 8'(s5_oc);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] dmask(input int n);
        if (m_w[n] >= 64) return '1;
        return (64'd1 << m_w[n]) - 64'd1;
    endfunction

    // Winner = valid channel with smallest priority rank. Round-robin rank is
    // the circular distance after the last winner; fixed rank is the index.
    function automatic int pick(input int n);
        int best = -1;
        int bd   = 1000;
        int d;
        for (int i = 0; i < m_nch[n]; i++) begin
            if (t_iv[n][i]) begin
                d = (m_mode[n] == 1) ? i : (i - m_last[n] - 1 + 2 * m_nch[n]) % m_nch[n];
                if (d < bd) begin bd = d; best = i; end
            end
        end
        return best;
    endfunction

    task automatic model_reset();
        for (int n = 0; n < NI; n++) begin
            m_ov[n] = 1'b0; m_od[n] = '0; m_oc[n] = 0; m_last[n] = m_nch[n] - 1;
        end
    endtask

    task automatic check_ready();
        logic [15:0] e;
        for (int n = 0; n < NI; n++) begin
            m_g[n] = pick(n);
            e = '0;
            if (RST_n && (!m_ov[n] || t_or[n]) && m_g[n] >= 0) e = 16'd1 << m_g[n];
            chk($sformatf("in_ready[%0d]", n), 64'(a_ir[n]), 64'(e));
        end
    endtask

    task automatic check_outs();
        for (int n = 0; n < NI; n++) begin
            chk($sformatf("out_valid[%0d]", n), 64'(a_ov[n]), 64'(m_ov[n]));
            chk($sformatf("out_data[%0d]", n), a_od[n], m_od[n]);
            chk($sformatf("out_ch[%0d]", n), 64'(a_oc[n]), 64'(m_oc[n]));
        end
    endtask

    task automatic model_edge();
        for (int n = 0; n < NI; n++) begin
            if (!m_ov[n] || t_or[n]) begin
                if (m_g[n] >= 0) begin
                    m_ov[n] = 1'b1; m_od[n] = t_d[n][m_g[n]] & dmask(n);
                    m_oc[n] = m_g[n]; m_last[n] = m_g[n];
                end else begin
                    m_ov[n] = 1'b0;
                end
            end
        end
    endtask

    // One clock: check accepts mid-cycle, take the edge, check outputs.
    task automatic step();
        #1;
        check_ready();
        @(posedge CLK);
        model_edge();
        #1;
        check_outs();
    endtask

    task automatic async_reset();
        #2;
        RST_n = 1'b0;
        #1;
        model_reset();
        check_outs();
        check_ready();
        @(posedge CLK);
        #2;
        RST_n = 1'b1;
    endtask

    typedef struct {
        logic [3:0]  iv;
        logic        ordy;
        logic [3:0]  rdy;
        logic        ov;
        logic [1:0]  ch;
        logic [31:0] d;
    } vec_t;

    vec_t tbl[11];

    initial begin
        for (int k = 0; k < 8; k++)
            tbl[k] = '{4'hF, 1'b1, 4'(1 << (k % 4)), 1'b1, 2'(k % 4), 32'hA0 + 32'(k % 4)};
        tbl[8]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 32'hA2};
        tbl[9]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2, 32'hA2};
        tbl[10] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2, 32'hA2};

        RST_n = 1'b0;
        for (int n = 0; n < NI; n++) begin
            t_iv[n] = '0; t_or[n] = 1'b1;
            for (int c = 0; c < 16; c++) t_d[n][c] = {$urandom, $urandom};
        end
        for (int c = 0; c < 4; c++) begin
            t_d[0][c] = 64'hA0 + 64'(c);
            t_d[1][c] = 64'hB0 + 64'(c);
        end
        t_iv[0] = 16'hF;          // requests present during reset: no accepts
        #1;
        model_reset();
        check_outs();
        check_ready();
        @(posedge CLK);
        @(posedge CLK);
        #2;
        RST_n = 1'b1;

        // Round-robin fairness, single beat, drain
        for (int k = 0; k < 11; k++) begin
            t_iv[0] = 16'(tbl[k].iv);
            t_or[0] = tbl[k].ordy;
            #1;
            chk($sformatf("tbl%0d in_ready", k), 64'(rr_ir), 64'(tbl[k].rdy));
            step();
            chk($sformatf("tbl%0d out_valid", k), 64'(rr_ov), 64'(tbl[k].ov));
            chk($sformatf("tbl%0d out_ch", k), 64'(rr_oc), 64'(tbl[k].ch));
            chk($sformatf("tbl%0d out_data", k), 64'(rr_od), 64'(tbl[k].d));
        end

        // Backpressure hold
        t_d[0][1] = 64'hDEADBEEF;
        t_iv[0] = 16'b0010; t_or[0] = 1'b0;
        step();
        chk("bp load data", 64'(rr_od), 64'hDEADBEEF);
        t_iv[0] = 16'b0100;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp in_ready", 64'(rr_ir), 64'h0);
            step();
            chk("bp hold data", 64'(rr_od), 64'hDEADBEEF);
            chk("bp hold valid", 64'(rr_ov), 64'h1);
        end
        t_or[0] = 1'b1;
        #1;
        chk("bp release in_ready", 64'(rr_ir), 64'b0100);
        step();
        chk("bp release data", 64'(rr_od), 64'hA2);
        chk("bp release ch", 64'(rr_oc), 64'd2);

        // Reset while holding a word, then 1001 goes to channel 0
        t_iv[0] = 16'b0000;
        #2;
        RST_n = 1'b0;
        #1;
        chk("async rst valid", 64'(rr_ov), 64'h0);
        chk("async rst data", 64'(rr_od), 64'h0);
        model_reset();
        check_outs();
        @(posedge CLK);
        #2;
        RST_n = 1'b1;
        t_iv[0] = 16'b1001;
        #1;
        chk("post rst in_ready", 64'(rr_ir), 64'b0001);
        step();
        chk("post rst ch", 64'(rr_oc), 64'd0);
        t_iv[0] = '0;

        // Fixed priority starves channel 3
        t_iv[1] = 16'b1010; t_or[1] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("fp in_ready", 64'(fp_ir), 64'b0010);
            step();
            chk("fp ch", 64'(fp_oc), 64'd1);
        end
        t_iv[1] = '0;

        // Fairness on the NCH=2 and NCH=5 builds
        t_iv[2] = 16'b11; t_iv[3] = 16'b11111;
        for (int k = 0; k < 10; k++) begin
            step();
            chk("s2 fair ch", 64'(s2_oc), 64'(k % 2));
            chk("s5 fair ch", 64'(s5_oc), 64'(k % 5));
        end

        // Random traffic against the model
        for (int it = 0; it < 400; it++) begin
            if (it == 200) async_reset();
            for (int n = 0; n < NI; n++) begin
                t_iv[n] = ($urandom_range(0, 7) == 0) ? 16'h0
                        : 16'($urandom) & 16'((1 << m_nch[n]) - 1);
                t_or[n] = ($urandom_range(0, 3) != 0);
                for (int c = 0; c < m_nch[n]; c++) t_d[n][c] = {$urandom, $urandom};
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
